dm_pipe: RTL and testbench

Parametrised, handshaked data memory for the pipelined RV32I core, sitting in the MEM stage between the load/store unit and the on-chip data array. It accepts one load or store per cycle over a valid/ready request channel and returns a registered response one cycle later over a valid/ready response channel. Loads are correctly sign- or zero-extended. Out-of-range accesses, illegal store types and misaligned accesses are reported as faults instead of being silently truncated.

---
 rtl/dm_pipe.sv | 188 ++++++++++++++++++
 tb/tb_dm_pipe.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dm_pipe.sv
// dm_pipe: handshaked single-cycle data memory for the RV32I MEM stage.
// Accepts one load/store per cycle and returns a registered response one edge later.
// Optional feature macro: DM_MISALIGN_TRAP_EN (misaligned half/word accesses fault
// instead of being aligned down).
// Ports:
//   clk, rstn                 clock, async active-low reset
//   req_valid/req_ready       request handshake (req_ready is combinational)
//   req_we, req_type          store flag, DM_* access type
//   req_addr, req_wdata       byte address, store data
//   rsp_valid/rsp_ready       response handshake
//   rsp_rdata, rsp_fault      registered load result, fault flag
module dm_pipe #(
    parameter int unsigned DEPTH     = 128,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam logic [31:0] SPAN   = 32'(DEPTH * 4);

    // Access type encodings shared with the core's control decoder
    localparam logic [2:0] DM_WORD              = 3'd0;
    localparam logic [2:0] DM_HALFWORD          = 3'd1;
    localparam logic [2:0] DM_HALFWORD_UNSIGNED = 3'd2;
    localparam logic [2:0] DM_BYTE              = 3'd3;
    localparam logic [2:0] DM_BYTE_UNSIGNED     = 3'd4;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;
    logic [31:0] mem_q [DEPTH];

    logic [31:0]   off;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          in_range;
    logic          type_bad;
    logic          misalign;
    logic          fault_c;
    logic          accept;
    logic          mem_we;
    logic [31:0]   rd_word;
    logic [15:0]   rd_half;
    logic [7:0]    rd_byte;
    logic [31:0]   load_data;
    logic [3:0]    st_be;
    logic [31:0]   st_data;

    assign rsp_valid = (state_q == S_FULL);
    assign rsp_rdata = rdata_q;
    assign rsp_fault = fault_q;
    assign req_ready = !rsp_valid || rsp_ready;
    assign accept    = req_valid && req_ready;

    // Address decode relative to the array base
    always_comb begin
        off      = req_addr - BASE_ADDR;
        in_range = (off < SPAN);
        idx      = off[AW+1:2];
        lane     = off[1:0];
    end

    // Fault classification
    always_comb begin
        if (req_we) begin
            type_bad = !((req_type == DM_WORD) || (req_type == DM_HALFWORD) ||
                         (req_type == DM_BYTE));
        end else begin
            type_bad = (req_type > DM_BYTE_UNSIGNED);
        end
`ifdef DM_MISALIGN_TRAP_EN
        misalign = ((req_type == DM_WORD) && (lane != 2'd0)) ||
                   (((req_type == DM_HALFWORD) || (req_type == DM_HALFWORD_UNSIGNED)) &&
                    lane[0]);
`else
        misalign = 1'b0;
`endif
        fault_c = !in_range || type_bad || misalign;
        mem_we  = accept && req_we && !fault_c;
    end

    // Load lane extraction; misaligned half/word addresses fall back to the aligned lane
    always_comb begin
        rd_word = mem_q[idx];
        rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (lane)
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        case (req_type)
            DM_WORD:              load_data = rd_word;
            DM_HALFWORD:          load_data = {{16{rd_half[15]}}, rd_half};
            DM_HALFWORD_UNSIGNED: load_data = {16'h0000, rd_half};
            DM_BYTE:              load_data = {{24{rd_byte[7]}}, rd_byte};
            DM_BYTE_UNSIGNED:     load_data = {24'h000000, rd_byte};
            default:              load_data = 32'h0000_0000;
        endcase
    end

    // Store byte enables and lane-replicated data
    always_comb begin
        st_be   = 4'b0000;
        st_data = req_wdata;
        case (req_type)
            DM_WORD: st_be = 4'b1111;
            DM_HALFWORD: begin
                st_be   = lane[1] ? 4'b1100 : 4'b0011;
                st_data = {2{req_wdata[15:0]}};
            end
            DM_BYTE: begin
                st_be   = 4'(4'b0001 << lane);
                st_data = {4{req_wdata[7:0]}};
            end
            default: st_be = 4'b0000;
        endcase
    end

    // Response FSM next state and response payload
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    state_d = S_FULL;
                end
            end
            S_FULL: begin
                if (accept) begin
                    state_d = S_FULL;
                end else if (rsp_ready) begin
                    state_d = S_EMPTY;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        if (accept) begin
            fault_d = fault_c;
            rdata_d = (fault_c || req_we) ? 32'h0000_0000 : load_data;
        end
    end

    // Response registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_EMPTY;
            rdata_q <= 32'h0000_0000;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    // Data array: contents are not reset, but writes are blocked while rstn is low
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
        end else if (mem_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (st_be[b]) begin
                    mem_q[idx][8*b +: 8] <= st_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dm_pipe.sv
// tb_dm_pipe: directed self-checking bench for dm_pipe (default DEPTH/BASE_ADDR).
module tb_dm_pipe;

    localparam logic [2:0] W  = 3'd0;
    localparam logic [2:0] H  = 3'd1;
    localparam logic [2:0] HU = 3'd2;
    localparam logic [2:0] B  = 3'd3;
    localparam logic [2:0] BU = 3'd4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_type;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    int checks = 0;
    int errors = 0;

    dm_pipe #(.DEPTH(128), .BASE_ADDR(32'h0000_0000)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_type  (req_type),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_fault (rsp_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One accepted request; the response is checked one edge later
    task automatic xfer(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd,
                        input logic exp_f, input string tag);
        req_valid = 1'b1;
        req_we    = we;
        req_type  = typ;
        req_addr  = addr;
        req_wdata = wdata;
        rsp_ready = 1'b1;
        #1;
        chk({tag, ".ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, ".rdata"}, rsp_rdata, exp_rd);
        chk({tag, ".fault"}, 32'(rsp_fault), 32'(exp_f));
    endtask

    task automatic idle(input string tag);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        rstn      = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_type  = W;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", 32'(rsp_valid), 32'd0);
        chk("rst.ready", 32'(req_ready), 32'd1);
        chk("rst.rdata", rsp_rdata, 32'd0);
        chk("rst.fault", 32'(rsp_fault), 32'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst.valid", 32'(rsp_valid), 32'd0);

        // Word round trip
        xfer(1'b1, W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "sw10");
        xfer(1'b0, W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "lw10");

        // Sub-word extension
        xfer(1'b1, W,  32'h20, 32'h80F07F81, 32'h0, 1'b0, "sw20");
        xfer(1'b0, B,  32'h20, 32'h0, 32'hFFFFFF81, 1'b0, "lb20");
        xfer(1'b0, BU, 32'h20, 32'h0, 32'h00000081, 1'b0, "lbu20");
        xfer(1'b0, B,  32'h21, 32'h0, 32'h0000007F, 1'b0, "lb21");
        xfer(1'b0, H,  32'h22, 32'h0, 32'hFFFF80F0, 1'b0, "lh22");
        xfer(1'b0, HU, 32'h22, 32'h0, 32'h000080F0, 1'b0, "lhu22");
        xfer(1'b0, B,  32'h23, 32'h0, 32'hFFFFFF80, 1'b0, "lb23");

        // Byte-masked stores (only the low byte/half of wdata may land)
        xfer(1'b1, W, 32'h30, 32'h0, 32'h0, 1'b0, "sw30");
        xfer(1'b1, B, 32'h33, 32'hFFFFFFAA, 32'h0, 1'b0, "sb33");
        xfer(1'b1, H, 32'h30, 32'hABCD1234, 32'h0, 1'b0, "sh30");
        xfer(1'b0, W, 32'h30, 32'h0, 32'hAA001234, 1'b0, "lw30");

        // Range boundary
        xfer(1'b1, W, 32'h1FC, 32'hCAFEF00D, 32'h0, 1'b0, "sw_last");
        xfer(1'b0, W, 32'h1FC, 32'h0, 32'hCAFEF00D, 1'b0, "lw_last");
        xfer(1'b0, W, 32'h200, 32'h0, 32'h0, 1'b1, "lw_oor");
        xfer(1'b0, W, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1, "lw_below");
        xfer(1'b1, W, 32'h200, 32'h1, 32'h0, 1'b1, "sw_oor");

        // Illegal types leave memory untouched
        xfer(1'b1, BU, 32'h30, 32'hFFFFFFFF, 32'h0, 1'b1, "sbu_bad");
        xfer(1'b1, HU, 32'h30, 32'hFFFFFFFF, 32'h0, 1'b1, "shu_bad");
        xfer(1'b1, 3'd7, 32'h30, 32'hFFFFFFFF, 32'h0, 1'b1, "st_unk");
        xfer(1'b0, 3'd6, 32'h30, 32'h0, 32'h0, 1'b1, "ld_unk");
        xfer(1'b0, W, 32'h30, 32'h0, 32'hAA001234, 1'b0, "lw30_kept");

        // Misalignment
`ifdef DM_MISALIGN_TRAP_EN
        xfer(1'b0, W, 32'h12, 32'h0, 32'h0, 1'b1, "lw12_trap");
        xfer(1'b1, H, 32'h11, 32'hFFFF, 32'h0, 1'b1, "sh11_trap");
        xfer(1'b0, H, 32'h13, 32'h0, 32'h0, 1'b1, "lh13_trap");
        xfer(1'b0, W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "lw10_kept");
`else
        xfer(1'b0, W, 32'h12, 32'h0, 32'hDEADBEEF, 1'b0, "lw12_align");
        xfer(1'b0, H, 32'h13, 32'h0, 32'hFFFFDEAD, 1'b0, "lh13_align");
`endif
        xfer(1'b0, B, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, "lb13");

        // Backpressure: response held, queued store blocked
        xfer(1'b1, W, 32'h40, 32'h0, 32'h0, 1'b0, "sw40_clr");
        idle("drain");
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_type  = W;
        req_addr  = 32'h10;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_first.valid", 32'(rsp_valid), 32'd1);
        chk("bp_first.rdata", rsp_rdata, 32'hDEADBEEF);
        req_we    = 1'b1;
        req_addr  = 32'h40;
        req_wdata = 32'h11111111;
        for (int i = 0; i < 3; i++) begin
            chk("bp.ready", 32'(req_ready), 32'd0);
            @(posedge clk);
            #1;
            chk("bp.valid", 32'(rsp_valid), 32'd1);
            chk("bp.rdata", rsp_rdata, 32'hDEADBEEF);
            chk("bp.fault", 32'(rsp_fault), 32'd0);
        end
        xfer(1'b0, W, 32'h40, 32'h0, 32'h0, 1'b0, "bp_nowrite");

        // Streaming, including store-then-load to the same word
        xfer(1'b1, W, 32'h40, 32'h11111111, 32'h0, 1'b0, "st_sw40");
        xfer(1'b0, W, 32'h40, 32'h0, 32'h11111111, 1'b0, "st_lw40");
        xfer(1'b0, W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "st_lw10");
        xfer(1'b0, W, 32'h20, 32'h0, 32'h80F07F81, 1'b0, "st_lw20");
        xfer(1'b0, W, 32'h30, 32'h0, 32'hAA001234, 1'b0, "st_lw30");
        idle("stream_end");

        // Reset mid-operation
        xfer(1'b1, W, 32'h60, 32'h0, 32'h0, 1'b0, "sw60_clr");
        xfer(1'b1, W, 32'h50, 32'h5A5A5A5A, 32'h0, 1'b0, "sw50");
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_type  = W;
        req_addr  = 32'h60;
        req_wdata = 32'h77777777;
        rstn      = 1'b0;
        #1;
        chk("rst_mid.valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rstn      = 1'b1;
        chk("rst_mid.fault", 32'(rsp_fault), 32'd0);
        xfer(1'b0, W, 32'h50, 32'h0, 32'h5A5A5A5A, 1'b0, "lw50_persist");
        xfer(1'b0, W, 32'h60, 32'h0, 32'h0, 1'b0, "lw60_dropped");
        idle("end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
